weight_bank: RTL and testbench
==============================

Name: weight_bank

Overview:
- Holds the 8 signed hidden-to-output weights that the output neuron consumes.
- Loads initial values when training starts.
- During a backprop pass, accepts one gradient per weight over a valid/ready handshake and applies w <= sat(w - (grad >>> LR_SHIFT)) in a shadow bank.
- Commits the shadow bank atomically, so the forward pass never sees partially updated weights.
- Sits between output_backprop (upstream, gradient producer) and output_neuron (downstream, weights consumer).

Parameters:
W_WIDTH, 8, weight width (signed two's complement)
N_WEIGHTS, 8, number of weights held
G_WIDTH, 16, gradient width (signed)
LR_SHIFT, 4, learning rate as an arithmetic right shift of the gradient

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  asynchronous, active-low reset
en_i  input  1  global enable; low freezes all state
init_i  input  1  load both banks from init_weights_i
init_weights_i  input  N_WEIGHTS*W_WIDTH  initial weights; weight k at bits [k*W_WIDTH +: W_WIDTH]
start_i  input  1  begin an update round (sampled only in IDLE)
grad_valid_i  input  1  gradient present on grad_i
grad_i  input  G_WIDTH  signed gradient for the current weight index
grad_ready_o  output  1  bank accepts a gradient this cycle
weights_o  output  N_WEIGHTS*W_WIDTH  active (committed) weights, same packing as init_weights_i
busy_o  output  1  high in UPDATE and COMMIT
update_done_o  output  1  one-cycle pulse when the new weights become visible on weights_o

Behaviour:
- Reset (rst_i low, asynchronous):
  - Active bank, shadow bank, index and outputs all clear to 0; state = IDLE.
  - Reset mid-round discards the round; no done pulse is issued.
- en_i low: no register changes; grad_ready_o forced 0; update_done_o forced 0; weights_o holds its value.
- IDLE:
  - init_i=1: at the next edge, both banks <= init_weights_i; stay in IDLE.
  - else start_i=1: shadow <= active, idx <= 0, go to UPDATE.
  - init_i has priority over start_i when both are high.
- UPDATE:
  - grad_ready_o = 1 (combinational from state and en_i).
  - A transfer happens when grad_valid_i & grad_ready_o at a rising edge. Then: delta = grad_i >>> LR_SHIFT (arithmetic); shadow[idx] <= sat(shadow[idx] - delta); idx <= idx + 1.
  - Gradients are consumed strictly in index order 0..N_WEIGHTS-1; valid bubbles are allowed, and idx and shadow hold through them.
  - The transfer at idx = N_WEIGHTS-1 moves the state to COMMIT; idx wraps to 0.
  - init_i=1 aborts the round: both banks <= init_weights_i, go to IDLE, no done pulse. init_i takes priority over a same-cycle transfer.
  - start_i is ignored outside IDLE.
- COMMIT (exactly one cycle): grad_ready_o = 0; at the edge, active <= shadow, update_done_o <= 1, go to IDLE.
- update_done_o is registered: high for exactly the first cycle in which weights_o shows the new values.
- Arithmetic:
  - Subtraction is evaluated at G_WIDTH+1 bits, signed.
  - Saturate to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1], i.e. [-128, 127]; never wrap.
  - The shift rounds toward -inf, so grad = -1 gives delta = -1.
- Latency, back-to-back: start sampled at cycle 0 -> grad_ready_o high in cycles 1..8 -> COMMIT in cycle 9 -> new weights_o and update_done_o in cycle 10 -> next start accepted from cycle 10.
- weights_o changes only on init load or at commit.

Test Plan:
1. Reset, then init_i with weights 1..8 -> weights_o = 1..8. Start, then 8 back-to-back grads of 16 -> weights_o = 0..7 with update_done_o high in cycle 10 only; busy_o high cycles 1..9.
2. Saturation: init w0=127, w1=-128, others 0. Grads -32768, 32767, then 0 x6 -> w0=127, w1=-128, others unchanged. Also grad -1 on w2=5 -> 6; grad 15 on w3=5 -> 5.
3. Bubbles: drop grad_valid_i for 3 cycles between transfers 2 and 3 (grads 16) -> same result as scenario 1. weights_o unchanged until commit; done pulse 3 cycles later.
4. Abort: mid-round after 4 transfers, raise init_i with weights all 10 -> weights_o = 10 x8, state IDLE, no update_done_o, next round starts at idx 0.
5. Freeze and reset: hold en_i low for 5 cycles mid-round -> no transfer, grad_ready_o=0, round resumes afterwards with correct result. Assert rst_i low asynchronously mid-round -> weights_o = 0 immediately, busy_o = 0.
6. Priority: init_i and start_i high together in IDLE -> load only, stays IDLE. start_i during UPDATE -> ignored.

Source files
------------

// File: rtl/weight_bank.sv
// Output-layer weight bank: shadow bank takes one gradient per weight, then commits atomically.
// Latency: start->ready next cycle; 8 transfers, one COMMIT cycle, new weights + done pulse after. Backpressure: ready only in UPDATE.
module weight_bank #(
    parameter int W_WIDTH   = 8,
    parameter int N_WEIGHTS = 8,
    parameter int G_WIDTH   = 16,
    parameter int LR_SHIFT  = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic                           init_i,
    input  logic [N_WEIGHTS*W_WIDTH-1:0]   init_weights_i,
    input  logic                           start_i,
    input  logic                           grad_valid_i,
    input  logic [G_WIDTH-1:0]             grad_i,
    output logic                           grad_ready_o,
    output logic [N_WEIGHTS*W_WIDTH-1:0]   weights_o,
    output logic                           busy_o,
    output logic                           update_done_o
);

    localparam int IDX_W = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
    localparam logic signed [G_WIDTH:0] W_MAX = (G_WIDTH+1)'((2 ** (W_WIDTH-1)) - 1);
    localparam logic signed [G_WIDTH:0] W_MIN = (G_WIDTH+1)'(-(2 ** (W_WIDTH-1)));
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WEIGHTS-1);

    typedef logic [N_WEIGHTS-1:0][W_WIDTH-1:0] bank_t;
    typedef enum logic [1:0] {IDLE, UPDATE, COMMIT} state_t;

    state_t            state_q, state_d;
    bank_t             active_q, active_d;
    bank_t             shadow_q, shadow_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              done_q, done_d;
    bank_t             init_bank;

    assign init_bank = init_weights_i;

    // Difference is formed one bit wider than the gradient so no operand combination can wrap.
    function automatic logic [W_WIDTH-1:0] sat_sub(input logic [W_WIDTH-1:0] w,
                                                   input logic [G_WIDTH-1:0] g);
        logic signed [G_WIDTH-1:0] delta;
        logic signed [G_WIDTH:0]   diff;
        delta = $signed(g) >>> LR_SHIFT;
        diff  = $signed({{(G_WIDTH+1-W_WIDTH){w[W_WIDTH-1]}}, w})
              - $signed({delta[G_WIDTH-1], delta});
        if (diff > W_MAX)
            return W_MAX[W_WIDTH-1:0];
        else if (diff < W_MIN)
            return W_MIN[W_WIDTH-1:0];
        else
            return diff[W_WIDTH-1:0];
    endfunction

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        done_d   = done_q;
        if (en_i) begin
            done_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (init_i) begin
                        active_d = init_bank;
                        shadow_d = init_bank;
                    end else if (start_i) begin
                        shadow_d = active_q;
                        idx_d    = '0;
                        state_d  = UPDATE;
                    end
                end
                UPDATE: begin
                    if (init_i) begin
                        active_d = init_bank;
                        shadow_d = init_bank;
                        idx_d    = '0;
                        state_d  = IDLE;
                    end else if (grad_valid_i) begin
                        shadow_d[idx_q] = sat_sub(shadow_q[idx_q], grad_i);
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            state_d = COMMIT;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    active_d = shadow_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            active_q <= '0;
            shadow_q <= '0;
            idx_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
        end
    end

    assign grad_ready_o  = en_i && (state_q == UPDATE);
    assign busy_o        = (state_q == UPDATE) || (state_q == COMMIT);
    assign update_done_o = done_q && en_i;
    assign weights_o     = active_q;

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank: load, update rounds, saturation, bubbles, abort, freeze, reset, priority.
module tb_weight_bank;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i = 1'b1;
    logic        init_i = 1'b0;
    logic [63:0] init_weights_i = '0;
    logic        start_i = 1'b0;
    logic        grad_valid_i = 1'b0;
    logic [15:0] grad_i = '0;
    logic        grad_ready_o;
    logic [63:0] weights_o;
    logic        busy_o;
    logic        update_done_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] gq [8];

    weight_bank dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .init_i         (init_i),
        .init_weights_i (init_weights_i),
        .start_i        (start_i),
        .grad_valid_i   (grad_valid_i),
        .grad_i         (grad_i),
        .grad_ready_o   (grad_ready_o),
        .weights_o      (weights_o),
        .busy_o         (busy_o),
        .update_done_o  (update_done_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [63:0] pk(input int v0, input int v1, input int v2, input int v3,
                                       input int v4, input int v5, input int v6, input int v7);
        return {v7[7:0], v6[7:0], v5[7:0], v4[7:0], v3[7:0], v2[7:0], v1[7:0], v0[7:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic load(input logic [63:0] w);
        init_i = 1'b1;
        init_weights_i = w;
        step();
        init_i = 1'b0;
        #1;
    endtask

    // Back-to-back round using gq[]; start_i optionally left high during UPDATE.
    task automatic run_round(input string tag, input logic [63:0] old_w, input logic [63:0] new_w,
                             input bit keep_start);
        start_i = 1'b1;
        step();
        start_i = keep_start;
        for (int i = 0; i < 8; i++) begin
            grad_valid_i = 1'b1;
            grad_i = gq[i];
            #1;
            check({tag, "_ready"}, {63'd0, grad_ready_o}, 64'd1);
            check({tag, "_busy"}, {63'd0, busy_o}, 64'd1);
            step();
        end
        grad_valid_i = 1'b0;
        start_i = 1'b0;
        #1;
        check({tag, "_commit_ready"}, {63'd0, grad_ready_o}, 64'd0);
        check({tag, "_commit_busy"}, {63'd0, busy_o}, 64'd1);
        check({tag, "_commit_done"}, {63'd0, update_done_o}, 64'd0);
        check({tag, "_commit_w_old"}, weights_o, old_w);
        step();
        check({tag, "_done"}, {63'd0, update_done_o}, 64'd1);
        check({tag, "_w_new"}, weights_o, new_w);
        check({tag, "_idle_busy"}, {63'd0, busy_o}, 64'd0);
        step();
        check({tag, "_done_pulse"}, {63'd0, update_done_o}, 64'd0);
    endtask

    initial begin
        // Reset
        #12;
        check("rst_weights", weights_o, 64'd0);
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_ready", {63'd0, grad_ready_o}, 64'd0);
        check("rst_done", {63'd0, update_done_o}, 64'd0);
        rst_i = 1'b1;
        step();

        // 1: basic round
        load(pk(1, 2, 3, 4, 5, 6, 7, 8));
        check("init_w", weights_o, pk(1, 2, 3, 4, 5, 6, 7, 8));
        check("init_busy", {63'd0, busy_o}, 64'd0);
        for (int i = 0; i < 8; i++) gq[i] = 16'd16;
        run_round("basic", pk(1, 2, 3, 4, 5, 6, 7, 8), pk(0, 1, 2, 3, 4, 5, 6, 7), 1'b0);

        // 2: saturation and shift rounding
        load(pk(127, -128, 5, 5, 0, -120, 0, 0));
        gq[0] = 16'h8000; gq[1] = 16'h7fff; gq[2] = 16'hffff; gq[3] = 16'd15;
        gq[4] = 16'd0;    gq[5] = 16'd320;  gq[6] = 16'd0;    gq[7] = 16'd0;
        run_round("sat", pk(127, -128, 5, 5, 0, -120, 0, 0),
                  pk(127, -128, 6, 5, 0, -128, 0, 0), 1'b0);

        // 3: valid bubbles
        load(pk(1, 2, 3, 4, 5, 6, 7, 8));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        grad_i = 16'd16;
        for (int i = 0; i < 11; i++) begin
            grad_valid_i = !(i >= 3 && i < 6);
            #1;
            check("bub_ready", {63'd0, grad_ready_o}, 64'd1);
            check("bub_w_hold", weights_o, pk(1, 2, 3, 4, 5, 6, 7, 8));
            step();
        end
        grad_valid_i = 1'b0;
        #1;
        check("bub_commit_done", {63'd0, update_done_o}, 64'd0);
        check("bub_commit_ready", {63'd0, grad_ready_o}, 64'd0);
        step();
        check("bub_done", {63'd0, update_done_o}, 64'd1);
        check("bub_w", weights_o, pk(0, 1, 2, 3, 4, 5, 6, 7));
        step();

        // 4: abort with init after 4 transfers
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        grad_valid_i = 1'b1;
        grad_i = 16'd160;
        repeat (4) step();
        init_i = 1'b1;
        init_weights_i = pk(10, 10, 10, 10, 10, 10, 10, 10);
        step();
        init_i = 1'b0;
        grad_valid_i = 1'b0;
        #1;
        check("abort_w", weights_o, pk(10, 10, 10, 10, 10, 10, 10, 10));
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_done", {63'd0, update_done_o}, 64'd0);
        step();
        check("abort_done2", {63'd0, update_done_o}, 64'd0);
        for (int i = 0; i < 8; i++) gq[i] = 16'd16;
        run_round("after_abort", pk(10, 10, 10, 10, 10, 10, 10, 10),
                  pk(9, 9, 9, 9, 9, 9, 9, 9), 1'b0);

        // 5a: freeze mid-round
        load(pk(1, 2, 3, 4, 5, 6, 7, 8));
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        grad_valid_i = 1'b1;
        grad_i = 16'd16;
        repeat (3) step();
        en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_ready", {63'd0, grad_ready_o}, 64'd0);
            check("frz_w", weights_o, pk(1, 2, 3, 4, 5, 6, 7, 8));
            step();
        end
        en_i = 1'b1;
        repeat (5) step();
        grad_valid_i = 1'b0;
        #1;
        check("frz_commit_busy", {63'd0, busy_o}, 64'd1);
        check("frz_commit_ready", {63'd0, grad_ready_o}, 64'd0);
        step();
        check("frz_done", {63'd0, update_done_o}, 64'd1);
        check("frz_w_new", weights_o, pk(0, 1, 2, 3, 4, 5, 6, 7));
        step();

        // 5b: asynchronous reset mid-round
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        grad_valid_i = 1'b1;
        repeat (2) step();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_w", weights_o, 64'd0);
        check("arst_busy", {63'd0, busy_o}, 64'd0);
        check("arst_ready", {63'd0, grad_ready_o}, 64'd0);
        grad_valid_i = 1'b0;
        step();
        rst_i = 1'b1;
        step();
        check("arst_done", {63'd0, update_done_o}, 64'd0);

        // 6: init beats start in IDLE; start ignored in UPDATE
        init_i = 1'b1;
        start_i = 1'b1;
        init_weights_i = pk(1, 2, 3, 4, 5, 6, 7, 8);
        step();
        init_i = 1'b0;
        start_i = 1'b0;
        #1;
        check("prio_w", weights_o, pk(1, 2, 3, 4, 5, 6, 7, 8));
        check("prio_busy", {63'd0, busy_o}, 64'd0);
        check("prio_ready", {63'd0, grad_ready_o}, 64'd0);
        run_round("start_in_upd", pk(1, 2, 3, 4, 5, 6, 7, 8), pk(0, 1, 2, 3, 4, 5, 6, 7), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
